// File: rtl/kronos_mem_arb.sv
// kronos_mem_arb: instr/data port arbiter onto one memory port; KRONOS_ARB_RR_EN selects round-robin ties.
module kronos_mem_arb #(
    parameter int MAX_HOLD = 2
) (
    input  logic        clk,
    input  logic        rstz,
    input  logic [31:0] instr_addr,
    output logic [31:0] instr_data,
    input  logic        instr_req,
    output logic        instr_ack,
    input  logic [31:0] data_addr,
    output logic [31:0] data_rd_data,
    input  logic [31:0] data_wr_data,
    input  logic [3:0]  data_wr_mask,
    input  logic        data_wr_en,
    input  logic        data_req,
    output logic        data_ack,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wr_data,
    output logic [3:0]  mem_wr_mask,
    output logic        mem_wr_en,
    output logic        mem_req,
    input  logic [31:0] mem_rd_data,
    input  logic        mem_ack
);
    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;
    state_t state, state_nx;
    logic last_grant;
    logic [3:0] hold_cnt;
    logic hold, tie_d, grant_d, grant_i;
    assign instr_data   = mem_rd_data;
    assign data_rd_data = mem_rd_data;
    assign instr_ack    = (state == BUSY_I) && mem_ack;
    assign data_ack     = (state == BUSY_D) && mem_ack;
    always_comb begin
        hold = data_req && last_grant && (hold_cnt < 4'(MAX_HOLD));
`ifdef KRONOS_ARB_RR_EN
        tie_d = !last_grant;
`else
        tie_d = 1'b1;
`endif
        grant_d  = data_req && (hold || !instr_req || tie_d);
        grant_i  = instr_req && !grant_d;
        state_nx = state;
        if (state == IDLE)
            state_nx = grant_d ? BUSY_D : grant_i ? BUSY_I : IDLE;
        else if (mem_ack)
            state_nx = IDLE;
    end
    always_ff @(posedge clk) begin
        if (!rstz) begin
            state       <= IDLE;
            mem_req     <= 1'b0;
            mem_wr_en   <= 1'b0;
            mem_addr    <= '0;
            mem_wr_data <= '0;
            mem_wr_mask <= '0;
            last_grant  <= 1'b0;
            hold_cnt    <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && (grant_d || grant_i)) begin
                mem_req     <= 1'b1;
                mem_addr    <= grant_d ? data_addr : instr_addr;
                mem_wr_data <= grant_d ? data_wr_data : '0;
                mem_wr_mask <= grant_d ? data_wr_mask : 4'hF;
                mem_wr_en   <= grant_d && data_wr_en;
                last_grant  <= grant_d;
                // consecutive data grants count up (saturating) so the hold rule can release instr
                hold_cnt    <= !grant_d ? 4'd0 : !last_grant ? 4'd1 :
                               (hold_cnt == 4'hF) ? 4'hF : hold_cnt + 4'd1;
            end else if (state != IDLE && mem_ack) begin
                mem_req   <= 1'b0;
                mem_wr_en <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_kronos_mem_arb.sv
// tb_kronos_mem_arb: randomized self-checking bench with a grant-policy reference model.
module tb_kronos_mem_arb;
    localparam int MAX_HOLD = 2;
    logic        clk = 0, rstz = 0;
    logic [31:0] instr_addr = 0, instr_data, data_addr = 0, data_rd_data, data_wr_data = 0;
    logic [3:0]  data_wr_mask = 0;
    logic        instr_req = 0, instr_ack, data_wr_en = 0, data_req = 0, data_ack;
    logic [31:0] mem_addr, mem_wr_data, mem_rd_data = 0;
    logic [3:0]  mem_wr_mask;
    logic        mem_wr_en, mem_req, mem_ack = 0;
    int n_checks = 0, n_fail = 0;
    bit m_last = 0;
    int m_hold = 0;

    typedef struct {
        logic issued, stable, iack, dack, req_after, we_after, we;
        logic [31:0] addr, wdata, rd, rdata_i, rdata_d;
        logic [3:0] mask;
    } obs_t;

    kronos_mem_arb #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk(clk), .rstz(rstz),
        .instr_addr(instr_addr), .instr_data(instr_data), .instr_req(instr_req), .instr_ack(instr_ack),
        .data_addr(data_addr), .data_rd_data(data_rd_data), .data_wr_data(data_wr_data),
        .data_wr_mask(data_wr_mask), .data_wr_en(data_wr_en), .data_req(data_req), .data_ack(data_ack),
        .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .mem_wr_mask(mem_wr_mask),
        .mem_wr_en(mem_wr_en), .mem_req(mem_req), .mem_rd_data(mem_rd_data), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Spec-level grant policy: hold rule, then single requester, then tie policy.
    function automatic bit model_pick(bit ireq, bit dreq);
        if (dreq && m_last && m_hold < MAX_HOLD) return 1'b1;
        if (!ireq) return dreq;
        if (!dreq) return 1'b0;
`ifdef KRONOS_ARB_RR_EN
        return !m_last;
`else
        return 1'b1;
`endif
    endfunction

    task automatic model_grant(input bit d);
        m_hold = !d ? 0 : !m_last ? 1 : (m_hold >= 15 ? 15 : m_hold + 1);
        m_last = d;
    endtask

    task automatic do_reset();
        rstz = 0;
        tick();
        rstz = 1;
        m_last = 0;
        m_hold = 0;
    endtask

    // Runs one memory transaction with the requests already presented; records what it saw.
    task automatic serve(input int lat, output obs_t o);
        tick();
        o.issued = mem_req; o.addr = mem_addr; o.wdata = mem_wr_data; o.mask = mem_wr_mask; o.we = mem_wr_en;
        o.stable = 1;
        repeat (lat) begin
            tick();
            if (mem_req !== o.issued || mem_addr !== o.addr || mem_wr_data !== o.wdata ||
                mem_wr_mask !== o.mask || mem_wr_en !== o.we || instr_ack || data_ack) o.stable = 0;
        end
        mem_rd_data = $urandom;
        o.rd = mem_rd_data;
        mem_ack = 1;
        #1;
        o.iack = instr_ack; o.dack = data_ack; o.rdata_i = instr_data; o.rdata_d = data_rd_data;
        @(posedge clk);
        #1;
        mem_ack = 0;
        o.req_after = mem_req;
        o.we_after = mem_wr_en;
    endtask

    task automatic test_reset();
        do_reset();
        mem_ack = 1;
        #1;
        n_checks++; if (instr_ack !== 1'b0) begin n_fail++; $display("FAIL reset_iack got %0b want 0", instr_ack); end
        n_checks++; if (data_ack !== 1'b0) begin n_fail++; $display("FAIL reset_dack got %0b want 0", data_ack); end
        tick();
        mem_ack = 0;
        n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got %0b want 0", mem_req); end
        n_checks++; if (mem_wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_we got %0b want 0", mem_wr_en); end
        n_checks++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr got %h want 0", mem_addr); end
        n_checks++; if (mem_wr_data !== 32'h0) begin n_fail++; $display("FAIL reset_wdata got %h want 0", mem_wr_data); end
        n_checks++; if (mem_wr_mask !== 4'h0) begin n_fail++; $display("FAIL reset_mask got %h want 0", mem_wr_mask); end
    endtask

    task automatic test_instr_read();
        obs_t o;
        instr_addr = 32'h100; instr_req = 1;
        serve(2, o);
        instr_req = 0;
        model_grant(0);
        n_checks++; if (o.issued !== 1'b1) begin n_fail++; $display("FAIL ird_issue got %0b want 1", o.issued); end
        n_checks++; if (o.addr !== 32'h100) begin n_fail++; $display("FAIL ird_addr got %h want 100", o.addr); end
        n_checks++; if (o.mask !== 4'hF) begin n_fail++; $display("FAIL ird_mask got %h want f", o.mask); end
        n_checks++; if (o.we !== 1'b0) begin n_fail++; $display("FAIL ird_we got %0b want 0", o.we); end
        n_checks++; if (o.wdata !== 32'h0) begin n_fail++; $display("FAIL ird_wdata got %h want 0", o.wdata); end
        n_checks++; if (o.stable !== 1'b1) begin n_fail++; $display("FAIL ird_stable got %0b want 1", o.stable); end
        n_checks++; if ({o.iack, o.dack} !== 2'b10) begin n_fail++; $display("FAIL ird_acks got %b want 10", {o.iack, o.dack}); end
        n_checks++; if (o.rdata_i !== o.rd) begin n_fail++; $display("FAIL ird_rdata got %h want %h", o.rdata_i, o.rd); end
        n_checks++; if (o.req_after !== 1'b0) begin n_fail++; $display("FAIL ird_req_after got %0b want 0", o.req_after); end
    endtask

    task automatic test_data_write();
        obs_t o;
        data_addr = 32'h204; data_wr_data = 32'hDEADBEEF; data_wr_mask = 4'h3; data_wr_en = 1; data_req = 1;
        serve(1, o);
        data_req = 0;
        model_grant(1);
        n_checks++; if (o.addr !== 32'h204) begin n_fail++; $display("FAIL dwr_addr got %h want 204", o.addr); end
        n_checks++; if (o.wdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL dwr_wdata got %h want deadbeef", o.wdata); end
        n_checks++; if (o.mask !== 4'h3) begin n_fail++; $display("FAIL dwr_mask got %h want 3", o.mask); end
        n_checks++; if (o.we !== 1'b1) begin n_fail++; $display("FAIL dwr_we got %0b want 1", o.we); end
        n_checks++; if ({o.iack, o.dack} !== 2'b01) begin n_fail++; $display("FAIL dwr_acks got %b want 01", {o.iack, o.dack}); end
        n_checks++; if (o.rdata_d !== o.rd) begin n_fail++; $display("FAIL dwr_rdata got %h want %h", o.rdata_d, o.rd); end
        n_checks++; if (o.req_after !== 1'b0 || o.we_after !== 1'b0) begin n_fail++; $display("FAIL dwr_clear got req=%0b we=%0b want 0 0", o.req_after, o.we_after); end
    endtask

    // Both ports request continuously from a fresh reset; grant order follows the model.
    task automatic test_tie();
        obs_t o;
        bit exp_d;
        int n_instr = 0;
        do_reset();
        instr_addr = 32'h1000; data_addr = 32'h200; data_wr_en = 0; data_wr_mask = 4'hF;
        instr_req = 1; data_req = 1;
        for (int k = 0; k < 6; k++) begin
            exp_d = model_pick(1, 1);
            serve($urandom_range(2, 0), o);
            model_grant(exp_d);
            n_checks++; if ({o.iack, o.dack} !== {!exp_d, exp_d}) begin n_fail++; $display("FAIL tie_winner k=%0d got %b want %b", k, {o.iack, o.dack}, {!exp_d, exp_d}); end
            n_checks++; if (o.addr !== (exp_d ? data_addr : instr_addr)) begin n_fail++; $display("FAIL tie_addr k=%0d got %h want %h", k, o.addr, exp_d ? data_addr : instr_addr); end
            if (o.iack) n_instr++;
            if (exp_d) data_addr += 4; else instr_addr += 4;
        end
`ifndef KRONOS_ARB_RR_EN
        n_checks++; if (n_instr !== 0) begin n_fail++; $display("FAIL tie_starve got %0d instr grants want 0", n_instr); end
`else
        n_checks++; if (n_instr !== 2) begin n_fail++; $display("FAIL tie_rr got %0d instr grants want 2", n_instr); end
`endif
        instr_req = 0; data_req = 0;
    endtask

    task automatic test_random();
        obs_t o;
        bit ip = 0, dp = 0, exp_d;
        logic [31:0] ia = 0, da = 0, dwd = 0;
        logic [3:0] dm = 0;
        logic dwe = 0;
        for (int n = 0; n < 40; n++) begin
            if (!ip && $urandom_range(1, 0) == 1) begin ip = 1; ia = $urandom; end
            if (!dp && ($urandom_range(1, 0) == 1 || !ip)) begin
                dp = 1; da = $urandom; dwd = $urandom; dm = 4'($urandom); dwe = 1'($urandom);
            end
            instr_req = ip; instr_addr = ia;
            data_req = dp; data_addr = da; data_wr_data = dwd; data_wr_mask = dm; data_wr_en = dwe;
            exp_d = model_pick(ip, dp);
            serve($urandom_range(3, 0), o);
            model_grant(exp_d);
            n_checks++; if ({o.iack, o.dack} !== {!exp_d, exp_d}) begin n_fail++; $display("FAIL rnd_winner n=%0d got %b want %b", n, {o.iack, o.dack}, {!exp_d, exp_d}); end
            n_checks++; if (o.addr !== (exp_d ? da : ia)) begin n_fail++; $display("FAIL rnd_addr n=%0d got %h want %h", n, o.addr, exp_d ? da : ia); end
            n_checks++; if (o.wdata !== (exp_d ? dwd : 32'h0)) begin n_fail++; $display("FAIL rnd_wdata n=%0d got %h want %h", n, o.wdata, exp_d ? dwd : 32'h0); end
            n_checks++; if (o.mask !== (exp_d ? dm : 4'hF)) begin n_fail++; $display("FAIL rnd_mask n=%0d got %h want %h", n, o.mask, exp_d ? dm : 4'hF); end
            n_checks++; if (o.we !== (exp_d && dwe)) begin n_fail++; $display("FAIL rnd_we n=%0d got %0b want %0b", n, o.we, exp_d && dwe); end
            n_checks++; if (o.issued !== 1'b1 || o.stable !== 1'b1) begin n_fail++; $display("FAIL rnd_hold n=%0d got issued=%0b stable=%0b want 1 1", n, o.issued, o.stable); end
            n_checks++; if ((exp_d ? o.rdata_d : o.rdata_i) !== o.rd) begin n_fail++; $display("FAIL rnd_rdata n=%0d got %h want %h", n, exp_d ? o.rdata_d : o.rdata_i, o.rd); end
            n_checks++; if (o.req_after !== 1'b0 || o.we_after !== 1'b0) begin n_fail++; $display("FAIL rnd_b2b n=%0d got req=%0b we=%0b want 0 0", n, o.req_after, o.we_after); end
            if (exp_d) dp = 0; else ip = 0;
            instr_req = ip; data_req = dp;
        end
        instr_req = 0; data_req = 0;
    endtask

    task automatic test_reset_mid();
        obs_t o;
        data_addr = 32'h300; data_wr_data = 32'h12345678; data_wr_mask = 4'h5; data_wr_en = 1; data_req = 1;
        tick();
        n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL rmid_issue got %0b want 1", mem_req); end
        tick();
        rstz = 0;
        tick();
        rstz = 1; data_req = 0;
        m_last = 0; m_hold = 0;
        mem_ack = 1;
        #1;
        n_checks++; if (data_ack !== 1'b0 || instr_ack !== 1'b0) begin n_fail++; $display("FAIL rmid_ack got d=%0b i=%0b want 0 0", data_ack, instr_ack); end
        tick();
        mem_ack = 0;
        n_checks++; if (mem_req !== 1'b0 || mem_wr_en !== 1'b0) begin n_fail++; $display("FAIL rmid_clear got req=%0b we=%0b want 0 0", mem_req, mem_wr_en); end
        instr_addr = 32'h440; instr_req = 1;
        serve(0, o);
        instr_req = 0;
        model_grant(0);
        n_checks++; if (o.issued !== 1'b1 || o.addr !== 32'h440) begin n_fail++; $display("FAIL rmid_idle got issued=%0b addr=%h want 1 440", o.issued, o.addr); end
        n_checks++; if ({o.iack, o.dack} !== 2'b10) begin n_fail++; $display("FAIL rmid_acks got %b want 10", {o.iack, o.dack}); end
    endtask

    initial begin
        test_reset();
        test_instr_read();
        test_data_write();
        test_tie();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
